// File: rtl/dense_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dense_layer_sequencer                                          |
// | Purpose  : Runs the dense compute engine for FC1 then FC2, requantizes    |
// |            FC1 results to int8 into a local buffer, copies that buffer    |
// |            into tensor RAM (address 0 up) as the FC2 input, and forwards  |
// |            raw FC2 int32 results to the host side.                        |
// | Options  : DENSE_SEQ_RELU_EN - apply ReLU before int8 saturation of FC1.  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dense_layer_sequencer #(
  parameter int MAX_IN  = 256,
  parameter int MAX_OUT = 64,
  parameter int ADDR_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(MAX_IN+1)-1:0]    fc1_in_size,
  input  logic [$clog2(MAX_OUT+1)-1:0]   fc1_out_size,
  input  logic [$clog2(MAX_OUT+1)-1:0]   fc2_out_size,
  input  logic [4:0]                     requant_shift,
  output logic                           eng_start_compute,
  output logic                           eng_input_valid,
  output logic [$clog2(MAX_IN+1)-1:0]    eng_input_size,
  output logic [$clog2(MAX_OUT+1)-1:0]   eng_output_size,
  output logic                           fc_layer_select,
  input  logic [31:0]                    eng_output_data,
  input  logic [$clog2(MAX_OUT)-1:0]     eng_output_channel,
  input  logic                           eng_output_ready,
  input  logic                           eng_complete,
  output logic                           wb_we,
  output logic [ADDR_W-1:0]              wb_addr,
  output logic [7:0]                     wb_data,
  output logic [31:0]                    result_data,
  output logic [$clog2(MAX_OUT)-1:0]     result_index,
  output logic                           result_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_error
);

  localparam int c_IN_W  = $clog2(MAX_IN + 1);
  localparam int c_OUT_W = $clog2(MAX_OUT + 1);
  localparam int c_CH_W  = $clog2(MAX_OUT);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_FC1_START = 3'd1;
  localparam logic [2:0] c_FC1_RUN   = 3'd2;
  localparam logic [2:0] c_COPY      = 3'd3;
  localparam logic [2:0] c_FC2_START = 3'd4;
  localparam logic [2:0] c_FC2_RUN   = 3'd5;
  localparam logic [2:0] c_DONE      = 3'd6;

  logic [2:0]          r_state;
  logic [c_IN_W-1:0]   r_fc1_in;
  logic [c_OUT_W-1:0]  r_fc1_out;
  logic [c_OUT_W-1:0]  r_fc2_out;
  logic [4:0]          r_shift;
  logic [c_OUT_W-1:0]  r_idx;
  logic                r_cfg_error;
  logic                r_result_valid;
  logic [31:0]         r_result_data;
  logic [c_CH_W-1:0]   r_result_index;
  logic [7:0]          r_buf [MAX_OUT];

  logic                w_cfg_ok;
  logic signed [31:0]  w_shifted;
  logic [7:0]          w_q;
  logic                w_fc1_phase;
  logic                w_fc2_phase;

  // Configuration check is done on the live inputs in the same cycle they are latched
  assign w_cfg_ok = (fc1_in_size  != '0) && (fc1_in_size  <= c_IN_W'(MAX_IN))  &&
                    (fc1_out_size != '0) && (fc1_out_size <= c_OUT_W'(MAX_OUT)) &&
                    (fc2_out_size != '0) && (fc2_out_size <= c_OUT_W'(MAX_OUT));

  assign w_shifted = $signed(eng_output_data) >>> r_shift;

  // FC1 requantization: arithmetic shift then clamp into int8
  always_comb begin
    w_q = w_shifted[7:0];
`ifdef DENSE_SEQ_RELU_EN
    if (w_shifted < 32'sd0)
      w_q = 8'd0;
    else if (w_shifted > 32'sd127)
      w_q = 8'd127;
`else
    if (w_shifted > 32'sd127)
      w_q = 8'h7F;
    else if (w_shifted < -32'sd128)
      w_q = 8'h80;
`endif
  end

  // Main sequencing FSM with latched job configuration and FC2 result forwarding
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= c_IDLE;
      r_fc1_in       <= '0;
      r_fc1_out      <= '0;
      r_fc2_out      <= '0;
      r_shift        <= '0;
      r_idx          <= '0;
      r_cfg_error    <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_result_index <= '0;
    end else begin
      r_cfg_error    <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_fc1_in  <= fc1_in_size;
            r_fc1_out <= fc1_out_size;
            r_fc2_out <= fc2_out_size;
            r_shift   <= requant_shift;
            if (w_cfg_ok)
              r_state <= c_FC1_START;
            else
              r_cfg_error <= 1'b1;
          end
        end
        c_FC1_START: r_state <= c_FC1_RUN;
        c_FC1_RUN: begin
          if (eng_complete) begin
            r_state <= c_COPY;
            r_idx   <= '0;
          end
        end
        c_COPY: begin
          if (r_idx == r_fc1_out - c_OUT_W'(1)) begin
            r_state <= c_FC2_START;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + c_OUT_W'(1);
          end
        end
        c_FC2_START: r_state <= c_FC2_RUN;
        c_FC2_RUN: begin
          if (eng_output_ready) begin
            r_result_valid <= 1'b1;
            r_result_data  <= eng_output_data;
            r_result_index <= eng_output_channel;
          end
          if (eng_complete)
            r_state <= c_DONE;
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Local int8 buffer filled by FC1 results in whatever channel order the engine emits
  always_ff @(posedge clk) begin
    if ((r_state == c_FC1_RUN) && eng_output_ready)
      r_buf[eng_output_channel] <= w_q;
  end

  assign w_fc1_phase = (r_state == c_FC1_START) || (r_state == c_FC1_RUN);
  assign w_fc2_phase = (r_state == c_FC2_START) || (r_state == c_FC2_RUN);

  assign eng_start_compute = (r_state == c_FC1_START) || (r_state == c_FC2_START);
  assign eng_input_valid   = eng_start_compute;
  assign fc_layer_select   = w_fc2_phase;
  assign eng_input_size    = w_fc1_phase ? r_fc1_in :
                             w_fc2_phase ? c_IN_W'(r_fc1_out) : '0;
  assign eng_output_size   = w_fc1_phase ? r_fc1_out :
                             w_fc2_phase ? r_fc2_out : '0;

  assign wb_we   = (r_state == c_COPY);
  assign wb_addr = wb_we ? ADDR_W'(r_idx) : '0;
  assign wb_data = wb_we ? r_buf[r_idx[c_CH_W-1:0]] : 8'd0;

  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign result_index = r_result_index;
  assign busy         = (r_state != c_IDLE) && (r_state != c_DONE);
  assign done         = (r_state == c_DONE);
  assign cfg_error    = r_cfg_error;

endmodule
`default_nettype wire
